// File: rtl/proc_imul_share_arbiter.sv
// Round-robin front end that lets several requesters share one pipelined multiplier.
// Winners are queued as tags in issue order so each product is steered back to its owner.
module proc_imul_share_arbiter #(
    parameter int p_num_reqs     = 2,
    parameter int p_max_inflight = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [p_num_reqs-1:0]      req_val,
    output logic [p_num_reqs-1:0]      req_rdy,
    input  logic [64*p_num_reqs-1:0]   req_msg,

    output logic [p_num_reqs-1:0]      resp_val,
    input  logic [p_num_reqs-1:0]      resp_rdy,
    output logic [31:0]                resp_msg,

    output logic                       mul_istream_val,
    input  logic                       mul_istream_rdy,
    output logic [63:0]                mul_istream_msg,

    input  logic                       mul_ostream_val,
    output logic                       mul_ostream_rdy,
    input  logic [31:0]                mul_ostream_msg,

    output logic                       err_orphan
);

    localparam int TW = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
    localparam int PW = $clog2(p_max_inflight);
    localparam int CW = PW + 1;

    typedef logic [TW-1:0] tag_t;

    tag_t            rr_ptr;
    tag_t            tags [p_max_inflight];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [CW-1:0]   count;

    tag_t            grant;
    tag_t            head;
    logic [TW:0]     cand;
    logic            not_full;
    logic            has_tag;
    logic            issue_val;
    logic            fire_in;
    logic            pop_rdy;
    logic            fire_out;

    // Rotating priority search starting at rr_ptr; later iterations are lower priority,
    // so the loop runs backwards and the closest requester overwrites the others.
    always_comb begin
        grant = rr_ptr;
        cand  = '0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (TW+1)'(k);
            if (cand >= (TW+1)'(p_num_reqs)) begin
                cand = cand - (TW+1)'(p_num_reqs);
            end
            if (req_val[cand[TW-1:0]]) begin
                grant = cand[TW-1:0];
            end
        end
    end

    assign not_full  = (count < CW'(p_max_inflight));
    assign has_tag   = (count != '0);
    assign head      = tags[head_ptr];
    assign issue_val = (|req_val) & not_full;
    assign fire_in   = issue_val & mul_istream_rdy;
    assign pop_rdy   = has_tag & resp_rdy[head];
    assign fire_out  = mul_ostream_val & pop_rdy;

    // Outputs are forced low while reset is held; internal handshakes stay ungated.
    always_comb begin
        req_rdy         = '0;
        resp_val        = '0;
        mul_istream_val = reset & issue_val;
        mul_istream_msg = req_msg[64*grant +: 64];
        mul_ostream_rdy = reset & pop_rdy;
        resp_msg        = mul_ostream_msg;
        if (reset && fire_in) begin
            req_rdy[grant] = 1'b1;
        end
        if (reset && mul_ostream_val && has_tag) begin
            resp_val[head] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (fire_in) begin
                tail_ptr <= tail_ptr + PW'(1);
                rr_ptr   <= (grant == TW'(p_num_reqs - 1)) ? '0 : grant + TW'(1);
            end
            if (fire_out) begin
                head_ptr <= head_ptr + PW'(1);
            end
            if (fire_in && !fire_out) begin
                count <= count + CW'(1);
            end else if (!fire_in && fire_out) begin
                count <= count - CW'(1);
            end
            if (mul_ostream_val && !has_tag) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (fire_in) begin
            tags[tail_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_proc_imul_share_arbiter.sv
// Randomized bench for proc_imul_share_arbiter with a behavioural multiplier and an
// in-order scoreboard of expected (requester, product) pairs.
module tb_proc_imul_share_arbiter;

    localparam int N    = 2;
    localparam int MAXF = 4;

    typedef struct {
        int          idx;
        logic [31:0] prod;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_val = '0;
    logic [N-1:0]     req_rdy;
    logic [64*N-1:0]  req_msg = '0;
    logic [N-1:0]     resp_val;
    logic [N-1:0]     resp_rdy = '0;
    logic [31:0]      resp_msg;
    logic             mul_istream_val;
    logic             mul_istream_rdy = 1'b0;
    logic [63:0]      mul_istream_msg;
    logic             mul_ostream_val = 1'b0;
    logic             mul_ostream_rdy;
    logic [31:0]      mul_ostream_msg = '0;
    logic             err_orphan;

    proc_imul_share_arbiter #(.p_num_reqs(N), .p_max_inflight(MAXF)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_msg         (req_msg),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_msg        (resp_msg),
        .mul_istream_val (mul_istream_val),
        .mul_istream_rdy (mul_istream_rdy),
        .mul_istream_msg (mul_istream_msg),
        .mul_ostream_val (mul_ostream_val),
        .mul_ostream_rdy (mul_ostream_rdy),
        .mul_ostream_msg (mul_ostream_msg),
        .err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        exp_q [$];
    logic [31:0] mul_q [$];
    logic [63:0] script_q1 [$];
    logic        pend_v [N];
    logic [63:0] pend_msg [N];
    int          rr_model = 0;
    bit          orphan_seen = 0;
    bit          orphan_pulse = 0;
    logic [N-1:0] req_mask = '0;
    int          p_req = 0;
    int          p_irdy = 100;
    int          p_oval = 100;
    int          p_rrdy = 100;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle: drive at negedge, check request side 1 time unit later, update models after
    // the monitor has consumed this cycle's response.
    task automatic apply_stimulus();
        bit          any;
        bit          space;
        bit          issue;
        int          win;
        int          idx;
        logic [31:0] p;
        logic [63:0] m;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i]) begin
                if (i == 1 && script_q1.size() > 0) begin
                    pend_v[i]   = 1'b1;
                    pend_msg[i] = script_q1.pop_front();
                end else if (req_mask[i] && $urandom_range(99) < p_req) begin
                    pend_v[i]   = 1'b1;
                    pend_msg[i] = {$urandom, $urandom};
                end
            end
            req_val[i]          = pend_v[i];
            req_msg[64*i +: 64] = pend_msg[i];
            resp_rdy[i]         = ($urandom_range(99) < p_rrdy);
        end
        mul_istream_rdy = ($urandom_range(99) < p_irdy);
        mul_ostream_val = (mul_q.size() > 0 && $urandom_range(99) < p_oval) || orphan_pulse;
        mul_ostream_msg = (mul_q.size() > 0) ? mul_q[0] : $urandom;
        #1;
        any = 0;
        win = 0;
        for (int k = 0; k < N; k++) begin
            idx = (rr_model + k) % N;
            if (!any && req_val[idx]) begin
                any = 1;
                win = idx;
            end
        end
        space   = (exp_q.size() < MAXF);
        issue   = any && space && mul_istream_rdy;
        exp_rdy = issue ? N'(1 << win) : '0;
        check_output("istream_val", 64'(mul_istream_val), 64'(any && space));
        check_output("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        check_output("err_orphan", 64'(err_orphan), 64'(orphan_seen));
        if (mul_ostream_val && exp_q.size() == 0) orphan_seen = 1;
        if (mul_ostream_val && mul_ostream_rdy && mul_q.size() > 0) void'(mul_q.pop_front());
        m = mul_istream_msg;
        #2;
        if (mul_istream_val && mul_istream_rdy) begin
            p = m[63:32] * m[31:0];
            mul_q.push_back(p);
        end
        if (issue) begin
            p = pend_msg[win][63:32] * pend_msg[win][31:0];
            exp_q.push_back('{win, p});
            pend_v[win] = 1'b0;
            rr_model    = (win + 1) % N;
        end
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) apply_stimulus();
    endtask

    task automatic drain();
        int budget;
        bit busy;
        req_mask = '0;
        p_irdy   = 100;
        p_oval   = 100;
        p_rrdy   = 100;
        budget   = 0;
        busy     = 1;
        while (busy && budget < 60) begin
            apply_stimulus();
            budget++;
            busy = (exp_q.size() != 0) || pend_v[0] || pend_v[1] || (script_q1.size() != 0);
        end
        check_output("drain_empty", 64'(busy), 64'(0));
    endtask

    // Asserts reset with all inputs active and checks outputs fall without a clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        reset           = 1'b0;
        req_val         = '1;
        resp_rdy        = '1;
        mul_istream_rdy = 1'b1;
        mul_ostream_val = 1'b1;
        #1;
        check_output("rst_req_rdy", 64'(req_rdy), 64'(0));
        check_output("rst_resp_val", 64'(resp_val), 64'(0));
        check_output("rst_istream_val", 64'(mul_istream_val), 64'(0));
        check_output("rst_ostream_rdy", 64'(mul_ostream_rdy), 64'(0));
        check_output("rst_err_orphan", 64'(err_orphan), 64'(0));
        exp_q.delete();
        mul_q.delete();
        script_q1.delete();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        rr_model    = 0;
        orphan_seen = 0;
        repeat (2) @(negedge clk);
        req_val         = '0;
        mul_ostream_val = 1'b0;
        reset           = 1'b1;
    endtask

    // Scoreboard monitor: compares every response-side presentation against the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (exp_q.size() == 0) begin
                    check_output("idle_resp_val", 64'(resp_val), 64'(0));
                    check_output("idle_ostream_rdy", 64'(mul_ostream_rdy), 64'(0));
                end else begin
                    e = exp_q[0];
                    check_output("ostream_rdy", 64'(mul_ostream_rdy), 64'(resp_rdy[e.idx]));
                    if (mul_ostream_val) begin
                        check_output("resp_val", 64'(resp_val), 64'(1 << e.idx));
                        check_output("resp_msg", 64'(resp_msg), 64'(e.prod));
                        if (resp_rdy[e.idx]) void'(exp_q.pop_front());
                    end else begin
                        check_output("resp_val_quiet", 64'(resp_val), 64'(0));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend_v[i]   = 1'b0;
            pend_msg[i] = '0;
        end
        pulse_reset();

        // Both requesters every cycle, fully open multiplier: grants must alternate.
        req_mask = 2'b11; p_req = 100; p_irdy = 100; p_oval = 100; p_rrdy = 100;
        run(20);
        drain();

        // Requester 1 alone with a fixed burst 3*4 .. 7*8.
        for (int a = 3; a <= 7; a++) script_q1.push_back({32'(a), 32'(a + 1)});
        req_mask = 2'b00;
        run(8);
        drain();

        // Multiplier output stalled: exactly MAXF issues, then release.
        req_mask = 2'b11; p_req = 100; p_oval = 0;
        run(10);
        p_oval = 100;
        run(10);
        drain();

        // Head requester stalled while the other is ready.
        req_mask = 2'b11; p_req = 100; p_oval = 100; p_rrdy = 40;
        run(40);
        drain();

        // General random traffic.
        req_mask = 2'b11; p_req = 60; p_irdy = 70; p_oval = 60; p_rrdy = 70;
        run(400);
        drain();

        // Orphan product on an empty tag queue.
        orphan_pulse = 1;
        apply_stimulus();
        orphan_pulse = 0;
        run(3);

        // Mid-burst reset clears everything including err_orphan.
        req_mask = 2'b11; p_req = 80; p_irdy = 80; p_oval = 50; p_rrdy = 80;
        run(15);
        pulse_reset();
        run(60);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
